i2c_req_arbiter: RTL
====================

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000, the maximum BUSY cycles before abort.
REQ-002 SHALL have parameter TO_W, default 16, the timeout counter width.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  2  per-requester transaction request; level, held until done or err.
REQ-006 SHALL have port req_addr  in  14  7-bit slave address per requester, packed {r1,r0}.
REQ-007 SHALL have port req_rw  in  2  per-requester direction: 1 = read, 0 = write.
REQ-008 SHALL have port req_cnt  in  8  4-bit byte count per requester, packed.
REQ-009 SHALL have port tx_data  in  16  8-bit write-data head of each requester TX FIFO, packed.
REQ-010 SHALL have port gnt  out  2  one-hot grant; 00 when idle.
REQ-011 SHALL have port tx_rd  out  2  TX FIFO pop strobe to the granted requester.
REQ-012 SHALL have port rx_wr  out  2  RX FIFO push strobe to the granted requester.
REQ-013 SHALL have port rx_data  out  8  read byte, valid with rx_wr.
REQ-014 SHALL have port done  out  2  one-cycle completion pulse.
REQ-015 SHALL have port err  out  2  one-cycle timeout pulse.
REQ-016 SHALL have master-side ports: m_start out 1, m_abort out 1, m_addr out 7, m_rw out 1, m_data_cnt out 4, m_data_in out 8, m_rdata in 8, m_txff_rd in 1, m_rxff_wr in 1, m_done in 1.

Function
REQ-017 SHALL implement FSM IDLE -> GRANT -> START -> BUSY -> FIN -> IDLE.
REQ-018 IDLE: when any req bit is high, SHALL pick a winner by round-robin, set gnt, register m_addr/m_rw/m_data_cnt from the winner, and go to GRANT next cycle.
REQ-019 Round-robin: pointer starts at 0 and the pointed requester wins ties; after FIN or abort, the pointer SHALL move to the other requester.
REQ-020 GRANT: SHALL pulse m_start high for exactly one cycle in START, then enter BUSY; the first edge after req is high sees gnt, and the third edge sees m_start.
REQ-021 m_addr/m_rw/m_data_cnt SHALL stay stable from GRANT through FIN regardless of req_* changes.
REQ-022 tx_rd[i] SHALL equal m_txff_rd & gnt[i], combinational; m_data_in SHALL be the granted requester's tx_data slice.
REQ-023 rx_wr[i] SHALL equal m_rxff_wr & gnt[i], combinational; rx_data SHALL equal m_rdata.
REQ-024 BUSY: m_done SHALL move to FIN; FIN SHALL pulse done[winner] for one cycle, clear gnt, and return to IDLE.
REQ-025 BUSY SHALL count cycles; at count == TIMEOUT-1 without m_done, it SHALL pulse m_abort and err[winner], clear gnt, and go to IDLE.
REQ-026 If m_done and timeout occur in the same cycle, done SHALL win; err SHALL NOT pulse.
REQ-027 m_done, m_txff_rd and m_rxff_wr outside BUSY SHALL be ignored with no strobes generated.
REQ-028 req_cnt = 0 SHALL be forwarded unchanged as an address-only probe.
REQ-029 Deassertion of the winner's req during a transaction SHALL NOT abort it.
REQ-030 The earliest re-grant after FIN SHALL be the IDLE cycle following FIN; no back-to-back grant without IDLE.

Reset
REQ-031 rst high SHALL asynchronously force IDLE, pointer = 0, and timeout counter = 0.
REQ-032 Under rst, gnt, done, err, m_start and m_abort SHALL be 0; m_addr, m_rw and m_data_cnt SHALL be 0.
REQ-033 Reset mid-transaction SHALL drop the transaction silently with no done or err pulse.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the requester-count constant (2), and the field widths (7 address, 4 count, 8 data).
REQ-035 A sub-module rr_arb2 SHALL contain the round-robin pointer and winner selection; everything else stays flat.

Verification
REQ-036 req=01, addr0=0x50, rw0=0, cnt0=3 -> gnt=01 one cycle later, m_start pulse, three tx_rd[0] pulses, done=01 after m_done.
REQ-037 req=11 held continuously -> grants alternate 01, 10, 01 with an IDLE gap between them.
REQ-038 Read by requester 1 (cnt=2, m_rdata=0xA5, then 0x3C) -> rx_wr=10 twice with matching rx_data; rx_wr[0] never asserted.
REQ-039 TIMEOUT=20, m_done never asserted -> m_abort and err=01 at BUSY cycle 20, gnt=00, and the next request is served.
REQ-040 rst asserted during BUSY -> all outputs 0 immediately; no done/err; a new req after reset is granted to requester 0 on a tie.

Source files
------------

// File: rtl/i2c_req_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester I2C master arbiter.
package i2c_req_arbiter_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_BUSY,
    ST_FIN
  } state_e;

endpackage

// File: rtl/i2c_req_arbiter_rr_arb2.sv
// Two-way round-robin pointer and winner selection.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       adv_idx_i,
  output logic       win_valid_o,
  output logic       win_idx_o
);

  logic ptr_q;

  // After a transaction the pointer favours whichever requester did not just win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (adv_i) begin
      ptr_q <= ~adv_idx_i;
    end
  end

  always_comb begin
    win_valid_o = |req_i;
    win_idx_o   = req_i[ptr_q] ? ptr_q : ~ptr_q;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates two transaction requesters onto one I2C master core.
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TO_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*CNT_W-1:0]  req_cnt,
  input  logic [NREQ*DATA_W-1:0] tx_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        tx_rd,
  output logic [NREQ-1:0]        rx_wr,
  output logic [DATA_W-1:0]      rx_data,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic                   m_start,
  output logic                   m_abort,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_rw,
  output logic [CNT_W-1:0]       m_data_cnt,
  output logic [DATA_W-1:0]      m_data_in,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_txff_rd,
  input  logic                   m_rxff_wr,
  input  logic                   m_done
);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [CNT_W-1:0]    dcnt_q, dcnt_d;
  logic [TO_W-1:0]     to_q, to_d;

  logic win_valid;
  logic win_idx;
  logic busy;
  logic abort;

  rr_arb2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .adv_i       ((state_q == ST_FIN) | abort),
    .adv_idx_i   (win_q),
    .win_valid_o (win_valid),
    .win_idx_o   (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      win_q   <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dcnt_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dcnt_q  <= dcnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dcnt_d  = dcnt_q;
    to_d    = to_q;
    m_start = 1'b0;
    abort   = 1'b0;
    done    = '0;
    err     = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          gnt_d   = win_idx ? 2'b10 : 2'b01;
          win_d   = win_idx;
          addr_d  = win_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          rw_d    = req_rw[win_idx];
          dcnt_d  = win_idx ? req_cnt[2*CNT_W-1:CNT_W] : req_cnt[CNT_W-1:0];
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_START;
      ST_START: begin
        m_start = 1'b1;
        to_d    = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // m_done is checked first so a completion on the timeout cycle is not reported as an error.
        if (m_done) begin
          state_d = ST_FIN;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          err     = gnt_q;
          gnt_d   = '0;
          to_d    = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_FIN: begin
        done    = gnt_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q == ST_BUSY);
  assign m_abort    = abort;
  assign gnt        = gnt_q;
  assign tx_rd      = {NREQ{m_txff_rd & busy}} & gnt_q;
  assign rx_wr      = {NREQ{m_rxff_wr & busy}} & gnt_q;
  assign rx_data    = m_rdata;
  assign m_addr     = addr_q;
  assign m_rw       = rw_q;
  assign m_data_cnt = dcnt_q;
  assign m_data_in  = gnt_q[1] ? tx_data[2*DATA_W-1:DATA_W] :
                      gnt_q[0] ? tx_data[DATA_W-1:0] : '0;

endmodule
